cpu_bus_responder: RTL
======================

Name: cpu_bus_responder

Overview:
- Memory/IO-side end of the CPU byte bus; answers the core's address/data/write strobes.
- Holds the 128 KB program/data RAM, a UART transmit FIFO, a UART receive byte slot, a free-running cycle counter and the program-stop latch.
- Drives the core's read-data bus and io_buffer_full; sits between the core top and the UART/simulation harness.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address width (2^17 bytes).
- TX_DEPTH, 8, UART TX FIFO entries (power of 2, >=4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  bus qualifier; accesses ignored when low
- cpu_a  in  32  byte address from core (bits 17:0 decoded)
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from core
- cpu_din  out  8  read data to core
- io_buffer_full  out  1  TX FIFO near full
- tx_data  out  8  byte to UART
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART accepts byte
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid, 1-cycle pulse
- program_stop  out  1  sticky stop flag
- tx_overflow  out  1  sticky, write hit full FIFO

Behaviour:
- Reset (rst_in=0, async): cpu_din=0, tx_valid=0, tx_data=0, io_buffer_full=0, program_stop=0, tx_overflow=0; FIFO empty, RX slot empty, counter=0. RAM contents are not reset.
- Decode: io = cpu_a[17:16]==2'b11; otherwise RAM at cpu_a[ADDR_WIDTH-1:0].
- Access qualification: accepted only on an edge with rdy_in=1. When rdy_in=0, cpu_din holds its value and no state changes except the counter and the TX drain.
- RAM write: byte stored at that edge; a read of the same address on the next cycle returns the new byte.
- RAM read: 1-cycle latency; cpu_din valid the cycle after the address is presented.
- IO read 0x30000: cpu_din = RX byte next cycle and the slot is cleared; empty slot returns 0x00.
- RX capture: a new rx_valid overwrites the slot. If rx_valid coincides with a pop, the new byte is kept.
- IO read 0x30004: latches counter into a snapshot and returns byte 0. Reads of 0x30005–0x30007 return snapshot bytes 1–3, little-endian. Other IO reads return 0.
- Counter: 32-bit, +1 every clk_in edge (independent of rdy_in), wraps 0xFFFFFFFF to 0.
- IO write 0x30000: 0x00 ignored; a nonzero byte is pushed to the FIFO. If the FIFO holds TX_DEPTH entries, the byte is dropped and tx_overflow is set.
- IO write 0x30004: pushes 0x00 unconditionally (uses the reserved slot) and sets program_stop. After program_stop, all writes (RAM and IO) are ignored; reads still serviced.
- TX drain: head is presented on tx_data with tx_valid=1 while the FIFO is non-empty; popped on tx_valid&tx_ready. Simultaneous push and pop keeps the count unchanged. Pointers wrap modulo TX_DEPTH.
- io_buffer_full = registered (count >= TX_DEPTH-2) to cover the core's one-cycle reaction lag; updated every edge.

Optional Feature:
- CYCLE_COUNTER_EN defined: counter and snapshot as above.
- Undefined: counter and snapshot are removed; reads of 0x30004–0x30007 return 0x00.

Test Plan:
- Write 0xA5 to 0x00010, read 0x00010 next cycle -> cpu_din=0xA5 one cycle after the read address.
- Writes 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> tx_data sequence 0x41, 0x42 only; tx_overflow=0.
- tx_ready=0, write 9 nonzero bytes (TX_DEPTH=8) -> io_buffer_full=1 after the 6th push; 9th dropped; tx_overflow=1.
- At counter=0x12345678, read 0x30004..0x30007 on consecutive cycles -> 0x78, 0x56, 0x34, 0x12 (snapshot coherent). Feature off: all 0x00.
- rx_valid with 0x5A, read 0x30000 twice -> 0x5A then 0x00.
- Write 0x30004 then write 0x77 to 0x00020 -> tx emits 0x00, program_stop=1, RAM[0x20] unchanged. Assert rst_in=0 mid-drain -> tx_valid=0 immediately.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: RAM, UART TX FIFO, RX slot, cycle counter and stop latch.
// Define CYCLE_COUNTER_EN to build the cycle counter and its snapshot reads.
`timescale 1ns/1ps
module cpu_bus_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop,
  output logic        tx_overflow
);
  localparam int PW = $clog2(TX_DEPTH);

  logic [7:0]          r_mem [2**ADDR_WIDTH];
  logic [7:0]          r_ram_q;
  logic [7:0]          r_io_q;
  logic                r_src_ram;
  logic [7:0]          r_fifo [TX_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [PW:0]         r_count;
  logic                r_stop_pend;
  logic                r_full;
  logic                r_ovf;
  logic                r_stop;
  logic [7:0]          r_rx;

  logic [PW:0]         w_count_nxt;
  logic [7:0]          w_io_rd;
  logic                w_is_io;
  logic [15:0]         w_off;
  logic [ADDR_WIDTH-1:0] w_ram_a;
  logic                w_rd;
  logic                w_wr;
  logic                w_ram_wr;
  logic                w_tx_wr;
  logic                w_stop_wr;
  logic                w_fifo_full;
  logic                w_fifo_ne;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_fifo_pop;
  logic                w_rx_pop;
  logic                w_unused;

  assign w_unused    = ^cpu_a[31:18];
  assign w_is_io     = cpu_a[17:16] == 2'b11;
  assign w_off       = cpu_a[15:0];
  assign w_ram_a     = cpu_a[ADDR_WIDTH-1:0];
  assign w_rd        = rdy_in & ~cpu_wr;
  assign w_wr        = rdy_in & cpu_wr & ~r_stop;
  assign w_ram_wr    = w_wr & ~w_is_io;
  assign w_tx_wr     = w_wr & w_is_io & (w_off == 16'h0000)
                     & (cpu_dout != 8'h00);
  assign w_stop_wr   = w_wr & w_is_io & (w_off == 16'h0004);
  assign w_fifo_full = r_count == (PW+1)'(TX_DEPTH);
  assign w_fifo_ne   = r_count != '0;
  assign w_push      = w_tx_wr & ~w_fifo_full;
  assign w_drop      = w_tx_wr & w_fifo_full;
  assign w_pop       = tx_valid & tx_ready;
  assign w_fifo_pop  = w_pop & w_fifo_ne;
  assign w_rx_pop    = w_rd & w_is_io & (w_off == 16'h0000);

  // The stop byte is always the last one sent, so it waits in its own
  // slot behind the FIFO instead of competing for a FIFO entry.
  assign tx_valid       = w_fifo_ne | r_stop_pend;
  assign tx_data        = w_fifo_ne ? r_fifo[r_rptr] : 8'h00;
  assign io_buffer_full = r_full;
  assign program_stop   = r_stop;
  assign tx_overflow    = r_ovf;
  assign cpu_din        = r_src_ram ? r_ram_q : r_io_q;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] r_cnt;
  logic [31:0] r_snap;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_rd & w_is_io & (w_off == 16'h0004))
        r_snap <= r_cnt;
    end
  end
`endif

  always_comb begin
    w_io_rd = 8'h00;
    case (w_off)
      16'h0000: w_io_rd = r_rx;
`ifdef CYCLE_COUNTER_EN
      16'h0004: w_io_rd = r_cnt[7:0];
      16'h0005: w_io_rd = r_snap[15:8];
      16'h0006: w_io_rd = r_snap[23:16];
      16'h0007: w_io_rd = r_snap[31:24];
`endif
      default:  w_io_rd = 8'h00;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_fifo_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_ram_wr)
      r_mem[w_ram_a] <= cpu_dout;
    if (w_rd & ~w_is_io)
      r_ram_q <= r_mem[w_ram_a];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < TX_DEPTH; i++)
        r_fifo[i] <= 8'h00;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_stop_pend <= 1'b0;
      r_full      <= 1'b0;
      r_ovf       <= 1'b0;
      r_stop      <= 1'b0;
      r_rx        <= 8'h00;
      r_io_q      <= 8'h00;
      r_src_ram   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= cpu_dout;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_fifo_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_pop & ~w_fifo_ne)
        r_stop_pend <= 1'b0;
      if (w_stop_wr) begin
        r_stop_pend <= 1'b1;
        r_stop      <= 1'b1;
      end
      r_count <= w_count_nxt;
      // Flag looks one push ahead so the core can react before overflow
      r_full  <= w_count_nxt >= (PW+1)'(TX_DEPTH - 2);
      if (w_drop)
        r_ovf <= 1'b1;
      if (rx_valid)
        r_rx <= rx_data;
      else if (w_rx_pop)
        r_rx <= 8'h00;
      if (w_rd) begin
        r_src_ram <= ~w_is_io;
        if (w_is_io)
          r_io_q <= w_io_rd;
      end
    end
  end

endmodule
